// File: rtl/mem_err_report_sched.sv
// Report scheduler: buffers checker mismatch records in a small FIFO, holds one
// pending status request, and shares the UART line printer between them round-robin.
module mem_err_report_sched #(
  parameter int AW = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_err_we,
  input  logic [31:0]   i_err_adr,
  input  logic [31:0]   i_err_dataw,
  input  logic [31:0]   i_err_datar,
  input  logic          i_stat_req,
  input  logic [31:0]   i_stat_adr,
  output logic [31:0]   o_prn_adr,
  output logic [31:0]   o_prn_dataw,
  output logic [31:0]   o_prn_datar,
  output logic          o_prn_we,
  input  logic          i_prn_ready,
  output logic [31:0]   o_err_count,
  output logic [15:0]   o_drop_count,
  output logic [AW:0]   o_fifo_level,
  output logic          o_idle
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

  state_t        state_q, state_d;
  logic [95:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          stat_pend_q;
  logic [31:0]   stat_adr_q;
  logic          last_src_q;
  logic [31:0]   err_cnt_q, err_cnt_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [31:0]   prn_adr_q, prn_dataw_q, prn_datar_q;

  logic          fifo_ne, fifo_full, start, pick_stat, pop, push;
  logic [95:0]   head;

  assign fifo_ne   = (count_q != '0);
  assign fifo_full = (count_q == (AW+1)'(DEPTH));
  assign start     = (state_q == S_IDLE) && i_prn_ready && (fifo_ne || stat_pend_q);
  // last_src_q = 1 means status was served last, so the FIFO has priority
  assign pick_stat = stat_pend_q && (!fifo_ne || !last_src_q);
  assign pop       = start && !pick_stat;
  assign push      = i_err_we && (!fifo_full || pop);
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_ISSUE;
      S_ISSUE:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!i_prn_ready) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (i_prn_ready) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d    = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    err_cnt_d  = err_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (i_err_we && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 32'd1;
    if (i_err_we && !push && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      stat_pend_q <= 1'b0;
      last_src_q  <= 1'b1;
      err_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      prn_adr_q   <= '0;
      prn_dataw_q <= '0;
      prn_datar_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      // a new request in the issue cycle keeps the flag set
      if (i_stat_req)             stat_pend_q <= 1'b1;
      else if (start && pick_stat) stat_pend_q <= 1'b0;
      if (start) last_src_q <= pick_stat;
      if (err_cnt_d != err_cnt_q)   err_cnt_q  <= err_cnt_d;
      if (drop_cnt_d != drop_cnt_q) drop_cnt_q <= drop_cnt_d;
      if (start) begin
        if (pick_stat) begin
          prn_adr_q   <= stat_adr_q;
          prn_dataw_q <= err_cnt_q;
          prn_datar_q <= {16'h0000, drop_cnt_q};
        end else begin
          prn_adr_q   <= head[95:64];
          prn_dataw_q <= head[63:32];
          prn_datar_q <= head[31:0];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {i_err_adr, i_err_dataw, i_err_datar};
    if (i_stat_req) stat_adr_q <= i_stat_adr;
  end

  assign o_prn_adr    = prn_adr_q;
  assign o_prn_dataw  = prn_dataw_q;
  assign o_prn_datar  = prn_datar_q;
  assign o_prn_we     = (state_q == S_ISSUE);
  assign o_err_count  = err_cnt_q;
  assign o_drop_count = drop_cnt_q;
  assign o_fifo_level = count_q;
  assign o_idle       = !fifo_ne && !stat_pend_q && (state_q == S_IDLE);
endmodule

// File: tb/tb_mem_err_report_sched.sv
// Randomized and directed bench for mem_err_report_sched with a queue-based
// reference model and a simple line-printer model.
module tb_mem_err_report_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        err_we, stat_req, prn_ready;
  logic [31:0] err_adr, err_dataw, err_datar, stat_adr;
  logic [31:0] prn_adr, prn_dataw, prn_datar, err_count;
  logic [15:0] drop_count;
  logic [2:0]  fifo_level;
  logic        prn_we, idle;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  logic [95:0] mq[$];
  logic [95:0] log_q[$];
  logic        m_pend, m_last;
  logic [31:0] m_sadr, m_err;
  logic [15:0] m_drop;

  // printer model controls
  logic hold = 1'b0;
  logic long_busy = 1'b0;
  int   p_phase = 0;
  int   p_cnt = 0;

  always #5 clk = ~clk;

  mem_err_report_sched #(.AW(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_err_we(err_we), .i_err_adr(err_adr), .i_err_dataw(err_dataw), .i_err_datar(err_datar),
    .i_stat_req(stat_req), .i_stat_adr(stat_adr),
    .o_prn_adr(prn_adr), .o_prn_dataw(prn_dataw), .o_prn_datar(prn_datar), .o_prn_we(prn_we),
    .i_prn_ready(prn_ready),
    .o_err_count(err_count), .o_drop_count(drop_count), .o_fifo_level(fifo_level), .o_idle(idle)
  );

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // printer: ready drops 1..3 cycles after a strobe, stays low for a while, then returns
  initial begin
    prn_ready = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      case (p_phase)
        0: if (prn_we) begin p_phase = 1; p_cnt = $urandom_range(1, 3); end
        1: begin
          p_cnt--;
          if (p_cnt == 0) begin p_phase = 2; p_cnt = long_busy ? 10 : $urandom_range(1, 5); end
        end
        default: begin
          p_cnt--;
          if (p_cnt == 0) p_phase = 0;
        end
      endcase
      prn_ready = !hold && (p_phase != 2);
    end
  end

  // monitor: capture inputs at the edge, inspect outputs just after it, advance the model
  initial begin
    logic        s_rst, s_we, s_req, s_rdy, use_stat, saw_low;
    logic [95:0] s_rec, exp_r;
    logic [31:0] s_sadr;
    saw_low = 1'b1;
    forever begin
      @(posedge clk);
      s_rst = rst_n; s_we = err_we; s_req = stat_req; s_rdy = prn_ready;
      s_rec = {err_adr, err_dataw, err_datar}; s_sadr = stat_adr;
      #1;
      if (!s_rst) begin
        mq.delete(); m_pend = 1'b0; m_last = 1'b1; m_err = '0; m_drop = '0;
        saw_low = 1'b1;
        chk("rst_we", prn_we, 0);
        chk("rst_prn", {prn_adr, prn_dataw, prn_datar}, 0);
        chk("rst_idle", idle, 1);
      end else begin
        if (!s_rdy) saw_low = 1'b1;
        if (prn_we) begin
          chk("we_on_ready", s_rdy, 1);
          chk("we_after_busy", saw_low, 1);
          saw_low = 1'b0;
          if (mq.size() == 0 && !m_pend) begin
            chk("we_spurious", prn_we, 0);
          end else begin
            use_stat = m_pend && (mq.size() == 0 || m_last == 1'b0);
            if (use_stat) begin
              exp_r = {m_sadr, m_err, 16'h0000, m_drop};
              m_pend = 1'b0;
            end else begin
              exp_r = mq.pop_front();
            end
            m_last = use_stat;
            chk("line", {prn_adr, prn_dataw, prn_datar}, exp_r);
            log_q.push_back({prn_adr, prn_dataw, prn_datar});
          end
        end
        if (s_we) begin
          if (m_err != '1) m_err++;
          if (mq.size() < 4) mq.push_back(s_rec);
          else if (m_drop != '1) m_drop++;
        end
        if (s_req) begin m_pend = 1'b1; m_sadr = s_sadr; end
        chk("err_count", err_count, m_err);
        chk("drop_count", drop_count, m_drop);
        chk("level", fifo_level, mq.size());
        if (mq.size() != 0 || m_pend) chk("idle_busy", idle, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic pulse_err(input logic [31:0] a, input logic [31:0] w, input logic [31:0] r);
    err_we = 1'b1; err_adr = a; err_dataw = w; err_datar = r;
    @(negedge clk);
    err_we = 1'b0;
  endtask

  task automatic pulse_stat(input logic [31:0] a);
    stat_req = 1'b1; stat_adr = a;
    @(negedge clk);
    stat_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (!(idle && p_phase == 0 && prn_ready) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < bound, 1);
  endtask

  task automatic do_reset();
    wait_idle("pre_reset", 200);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    log_q.delete();
  endtask

  initial begin
    logic [31:0] a[6];
    int n;
    rst_n = 1'b0; err_we = 1'b0; stat_req = 1'b0;
    err_adr = '0; err_dataw = '0; err_datar = '0; stat_adr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", idle, 1);
    chk("err_after_reset", err_count, 0);

    // single error: strobe two cycles after the input pulse
    pulse_err(32'h0000_0010, 32'hA5A5_A5A5, 32'hA5A4_A5A5);
    chk("lat_cyc1_we", prn_we, 0);
    @(negedge clk);
    chk("lat_cyc2_we", prn_we, 1);
    chk("single_line", {prn_adr, prn_dataw, prn_datar}, {32'h0000_0010, 32'hA5A5_A5A5, 32'hA5A4_A5A5});
    chk("single_err", err_count, 1);
    chk("single_drop", drop_count, 0);

    // overflow: six records into a depth-4 FIFO
    do_reset();
    hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a[i] = $urandom;
      pulse_err(a[i], $urandom, $urandom);
    end
    chk("ovf_level", fifo_level, 4);
    chk("ovf_err", err_count, 6);
    chk("ovf_drop", drop_count, 2);
    hold = 1'b0;
    wait_idle("ovf_drain", 300);
    chk("ovf_lines", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) chk("ovf_order", log_q[i][95:64], a[i]);
    chk("ovf_idle", idle, 1);

    // full FIFO with a pop on the same edge as the push
    do_reset();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) pulse_err($urandom, $urandom, $urandom);
    hold = 1'b0;
    pulse_err(32'hFEED_0004, 32'h1, 32'h2);
    chk("fullpop_level", fifo_level, 4);
    chk("fullpop_drop", drop_count, 0);
    chk("fullpop_err", err_count, 5);
    wait_idle("fullpop_drain", 300);
    chk("fullpop_last", log_q[log_q.size()-1][95:64], 32'hFEED_0004);

    // round-robin between three errors and one status request
    do_reset();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a[i] = 32'h100 + i;
      pulse_err(a[i], $urandom, $urandom);
    end
    pulse_stat(32'h0001_0000);
    hold = 1'b0;
    wait_idle("rr_drain", 300);
    chk("rr_lines", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("rr_0", log_q[0][95:64], a[0]);
      chk("rr_1", log_q[1], {32'h0001_0000, 32'd3, 32'd0});
      chk("rr_2", log_q[2][95:64], a[1]);
      chk("rr_3", log_q[3][95:64], a[2]);
    end

    // status collapse: latest address wins, one line only
    do_reset();
    hold = 1'b1;
    pulse_stat(32'd1); pulse_stat(32'd2); pulse_stat(32'd3);
    hold = 1'b0;
    wait_idle("col_drain", 300);
    chk("col_lines", log_q.size(), 1);
    if (log_q.size() == 1) chk("col_adr", log_q[0][95:64], 32'd3);

    // reset while the printer is busy with a line
    do_reset();
    long_busy = 1'b1;
    pulse_err(32'hDEAD_0001, 32'h11, 32'h22);
    n = 0;
    while (p_phase != 2 && n < 50) begin @(negedge clk); n++; end
    chk("mid_busy", n < 50, 1);
    long_busy = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_we", prn_we, 0);
    chk("mid_rst_adr", prn_adr, 0);
    rst_n = 1'b1;
    pulse_err(32'hBEEF_0002, 32'h33, 32'h44);
    chk("mid_ready_low", prn_ready, 0);
    wait_idle("mid_drain", 300);
    chk("mid_lines", log_q.size(), 2);
    chk("mid_last", log_q[log_q.size()-1][95:64], 32'hBEEF_0002);

    // saturation of the error counter
    do_reset();
    force dut.err_cnt_q = 32'hFFFF_FFFE;
    m_err = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.err_cnt_q;
    @(negedge clk);
    pulse_err($urandom, $urandom, $urandom);
    chk("sat_1", err_count, 32'hFFFF_FFFF);
    pulse_err($urandom, $urandom, $urandom);
    chk("sat_2", err_count, 32'hFFFF_FFFF);
    wait_idle("sat_drain", 300);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      err_we = ($urandom_range(0, 99) < 30);
      err_adr = $urandom; err_dataw = $urandom; err_datar = $urandom;
      stat_req = ($urandom_range(0, 99) < 8);
      stat_adr = $urandom;
      if ($urandom_range(0, 49) == 0) hold = !hold;
      @(negedge clk);
    end
    err_we = 1'b0; stat_req = 1'b0; hold = 1'b0;
    wait_idle("rnd_drain", 3000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
